// File: rtl/serial_alu_pkg.sv
// Shared encodings for the bit-serial add/subtract controller.
package serial_alu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Host-side handshake and operand/result bundle for serial_addsub_ctrl.
interface serial_addsub_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, cout, overflow
  );

endinterface

// File: rtl/adder.sv
// 1-bit full-adder cell shared by the serial datapath.
module adder (
  input  logic A,
  input  logic B,
  input  logic cin,
  output logic out,
  output logic cout
);

  assign out  = A ^ B ^ cin;
  assign cout = (A & B) | (cin & (A ^ B));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: feeds operands LSB-first through one
// full-adder cell, one bit per clock, with a start/busy/done handshake.
module serial_addsub_ctrl
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  serial_addsub_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic w_sum;
  logic w_cout;
  logic w_last;
  logic w_oob;
  logic w_accept;

  assign w_last   = (r_cnt == LastBit);
  // Only reachable for non-power-of-two widths after an upset; recover to IDLE.
  assign w_oob    = ({1'b0, r_cnt} >= (CNT_W + 1)'(WIDTH));
  assign w_accept = bus.start && ((r_state == StIdle) || (r_state == StDone));

  adder u_adder (
    .A    (r_sh_a[0]),
    .B    (r_sh_b[0]),
    .cin  (r_carry),
    .out  (w_sum),
    .cout (w_cout)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle, StDone: w_state_d = bus.start ? StRun : StIdle;
      StRun: begin
        if (w_oob) begin
          w_state_d = StIdle;
        end else if (w_last) begin
          w_state_d = StDone;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      // Subtract as A + ~B + 1: invert B here and seed the carry with 1.
      r_sh_a  <= bus.a;
      r_sh_b  <= (bus.op_sub == OP_ADD) ? bus.b : ~bus.b;
      r_carry <= (bus.op_sub == OP_SUB);
      r_cnt   <= '0;
    end else if (r_state == StRun && !w_oob) begin
      r_sh_a   <= r_sh_a >> 1;
      r_sh_b   <= r_sh_b >> 1;
      r_result <= {w_sum, r_result[WIDTH-1:1]};
      r_carry  <= w_cout;
      r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        r_cout <= w_cout;
        r_ovf  <= r_carry ^ w_cout;
      end
    end
  end

  assign bus.busy     = (r_state == StRun);
  assign bus.done     = (r_state == StDone);
  assign bus.result   = r_result;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl at WIDTH=8.
module tb_serial_addsub_ctrl;

  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             ov;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_addsub_ctrl #(.WIDTH(WIDTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic sub, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t           m;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   s;
    bb    = sub ? ~b : b;
    s     = {1'b0, a} + {1'b0, bb} + (WIDTH + 1)'(sub);
    m.res = s[WIDTH-1:0];
    m.co  = s[WIDTH];
    m.ov  = (a[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    return m;
  endfunction

  // Drive operands for the next edge; optionally record the expected result.
  task automatic drive_op(input logic sub, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit push);
    bus.start  = 1'b1;
    bus.op_sub = sub;
    bus.a      = a;
    bus.b      = b;
    if (push) sb.push_back(model(sub, a, b));
  endtask

  task automatic launch(input logic sub, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    drive_op(sub, a, b, 1'b1);
  endtask

  // Waits for done after a start edge; can poke a stray start mid-run or
  // chain a back-to-back 0x02+0x03 in the done cycle.
  task automatic wait_done(input string tag, input int inject_at, input bit chain);
    int busy_n;
    bit seen;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 1; i <= int'(WIDTH) + 4 && !seen; i++) begin
      @(negedge clk);
      if (i == inject_at) drive_op(1'b0, 8'h01, 8'h01, 1'b0);
      else bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        seen = 1'b1;
        check_val({tag, "_latency"}, i, WIDTH + 1);
        if (chain) drive_op(1'b0, 8'h02, 8'h03, 1'b1);
      end
    end
    check_val({tag, "_done_seen"}, 32'(seen), 1);
    check_val({tag, "_busy_cycles"}, busy_n, WIDTH);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      check_val("done_has_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_val("result", 32'(bus.result), 32'(e.res));
        check_val("cout", 32'(bus.cout), 32'(e.co));
        check_val("overflow", 32'(bus.overflow), 32'(e.ov));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(bus.busy), 0);
    check_val("rst_done", 32'(bus.done), 0);
    check_val("rst_result", 32'(bus.result), 0);
    check_val("rst_cout", 32'(bus.cout), 0);
    check_val("rst_overflow", 32'(bus.overflow), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    launch(1'b0, 8'h3C, 8'h55); wait_done("add_3c_55", 0, 1'b0);
    launch(1'b0, 8'hFF, 8'h01); wait_done("add_ff_01", 0, 1'b0);
    launch(1'b1, 8'h10, 8'h01); wait_done("sub_10_01", 0, 1'b0);
    launch(1'b1, 8'h80, 8'h01); wait_done("sub_80_01", 0, 1'b0);
    launch(1'b1, 8'h00, 8'h01); wait_done("sub_00_01", 0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("result_held", 32'(bus.result), 32'hFF);
    check_val("idle_after_done", 32'(bus.busy | bus.done), 0);

    launch(1'b0, 8'h3C, 8'h55); wait_done("ignore_start", 4, 1'b0);
    launch(1'b0, 8'h3C, 8'h55); wait_done("chain_first", 0, 1'b1);
    wait_done("chain_second", 0, 1'b0);

    // Reset mid-run at bit 4: discard the in-flight operation.
    @(negedge clk);
    drive_op(1'b0, 8'h3C, 8'h55, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check_val("midrst_busy", 32'(bus.busy), 0);
    check_val("midrst_done", 32'(bus.done), 0);
    check_val("midrst_result", 32'(bus.result), 0);
    check_val("midrst_cout", 32'(bus.cout), 0);
    check_val("midrst_overflow", 32'(bus.overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < int'(WIDTH) + 2; i++) begin
      @(negedge clk);
      check_val("no_done_after_rst", 32'(bus.done | bus.busy), 0);
    end

    launch(1'b0, 8'h7F, 8'h01); wait_done("add_7f_01", 0, 1'b0);
    repeat (2) @(negedge clk);
    check_val("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
